// File: rtl/memory_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// master = MEM stage (requester), slave = memory.
interface memory_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: issues loads/stores over a req/ready bus and stalls the front end.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT wait cycles (sticky mem_error).
module memory_access_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_W   = 4
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wre_in,
  input  logic              wb_sel_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  memory_access_stage_if.master dmem,
  output logic              stall,
  output logic              wre_memory,
  output logic              select_writeback_data_mux_memory,
  output logic [RD_W-1:0]   rd_memory,
  output logic [DATA_W-1:0] data_from_memory_out,
  output logic [DATA_W-1:0] calc_data_out,
  output logic              mem_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              access;
  logic              in_idle;
  logic              in_access;
  logic              done_ok;
  logic              abort;
  logic              req_o;
  logic              stall_o;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_q;

  assign access    = mem_read_in | mem_write_in;
  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign done_ok   = in_access & dmem.dmem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (access) state_d = ACCESS;
      ACCESS:  if (done_ok || abort) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_o   = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: stall_o = access;
      ACCESS: begin
        req_o   = 1'b1;
        stall_o = 1'b1;
      end
      DONE:    stall_o = 1'b0;
      default: stall_o = 1'b0;
    endcase
  end

  // Request fields are latched once in IDLE; upstream holds the slot stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (in_idle && access) begin
      addr_q  <= alu_result_in[ADDR_W-1:0];
      wdata_q <= store_data_in;
      we_q    <= mem_write_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q <= '0;
    end else if (done_ok && !we_q) begin
      load_q <= dmem.dmem_rdata;
    end else if (abort && !we_q) begin
      load_q <= '1;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_q;
  logic             err_q;

  // Abort on the TIMEOUT-th ACCESS cycle that still sees no ready.
  assign abort = in_access & ~dmem.dmem_ready &
                 (wait_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wait_q <= '0;
    else if (!in_access)     wait_q <= '0;
    else if (!dmem.dmem_ready) wait_q <= wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      err_q <= 1'b0;
    else if (abort) err_q <= 1'b1;
  end

  assign mem_error = err_q;
`else
  assign abort     = 1'b0;
  assign mem_error = 1'b0;
`endif

  assign dmem.dmem_req   = req_o;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign stall      = stall_o & ~reset;
  assign wre_memory = wre_in & ~stall_o & ~reset;

  assign select_writeback_data_mux_memory = wb_sel_in & ~reset;
  assign rd_memory     = reset ? '0 : rd_in;
  assign calc_data_out = reset ? '0 : alu_result_in;

  assign data_from_memory_out = load_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM-stage datapath and control that sits between the EX/MEM register and the MEM/WB register.
- Issues load/store requests to the data memory over a req/ready handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Presents the loaded data and the passed-through ALU result and control fields to the MEM/WB register.

Parameters:
- DATA_W, 16, data and ALU-result width.
- ADDR_W, 16, data-memory address width; address is alu_result_in[ADDR_W-1:0].
- RD_W, 4, destination register index width.
- TIMEOUT, 15, maximum ACCESS cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- mem_read_in  in  1  load in the current EX/MEM slot
- mem_write_in  in  1  store in the current EX/MEM slot
- wre_in  in  1  register-file write enable from EX/MEM
- wb_sel_in  in  1  writeback mux select from EX/MEM
- rd_in  in  RD_W  destination register from EX/MEM
- alu_result_in  in  DATA_W  ALU result; also the memory address
- store_data_in  in  DATA_W  store data
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  memory address
- dmem_wdata  out  DATA_W  write data
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready is 1
- dmem_ready  in  1  memory completes the access this cycle
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wre_memory  out  1  to MEM/WB
- select_writeback_data_mux_memory  out  1  to MEM/WB
- rd_memory  out  RD_W  to MEM/WB
- data_from_memory_out  out  DATA_W  load data to MEM/WB
- calc_data_out  out  DATA_W  ALU result to MEM/WB
- mem_error  out  1  sticky access-timeout flag

Behaviour:
- Reset values:
  - FSM = IDLE.
  - dmem_req, dmem_we, stall, mem_error = 0.
  - Load-data register = 0; dmem_addr and dmem_wdata registers = 0.
  - During reset: wre_memory = 0, select_writeback_data_mux_memory = 0, rd_memory = 0, data_from_memory_out = 0, calc_data_out = 0.
- Pass-through (combinational, all states):
  - calc_data_out = alu_result_in.
  - select_writeback_data_mux_memory = wb_sel_in.
  - rd_memory = rd_in.
- wre_memory = wre_in AND NOT stall, so a stalled slot never reaches MEM/WB as a write.
- data_from_memory_out = load-data register; holds its value between loads.
- Access detection: access = mem_read_in OR mem_write_in. When both are 1, a write is performed and the load register is unchanged.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - stall = access (combinational).
  - On access: register dmem_addr, dmem_wdata and dmem_we (= mem_write_in); dmem_req goes 1 next cycle; go to ACCESS.
  - Without access: stay in IDLE; stall = 0.
  - dmem_ready is ignored in IDLE.
- ACCESS:
  - dmem_req = 1; stall = 1; address, wdata and we are held.
  - On dmem_ready: if it is a read, capture dmem_rdata into the load register; drop dmem_req next cycle; go to DONE.
- DONE:
  - dmem_req = 0; stall = 0 for exactly one cycle, so the same EX/MEM slot is consumed without re-triggering.
  - Return to IDLE unconditionally.
- Latency:
  - Minimum memory access (ready in the first ACCESS cycle) = 3 cycles: 2 stall cycles, then DONE.
  - Each extra wait cycle on dmem_ready adds one stall cycle.
- Non-memory instruction: 0 added cycles; never stalls.
- Back-to-back memory instructions: the next instruction arrives after DONE, is seen in IDLE and starts a new access with no idle bubble.
- Inputs from EX/MEM are stable while stall = 1 (guaranteed upstream).
- Reset mid-ACCESS: dmem_req drops asynchronously, FSM returns to IDLE, and no partial data is captured.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle without dmem_ready.
  - When it reaches TIMEOUT, abort to DONE. The load register is written with all-ones if the access was a read. mem_error is set to 1 and stays 1 until reset.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - mem_error is tied to 0.

Test Plan:
- ALU op, wre_in = 1, rd_in = 4'h3, alu_result_in = 16'h1234 → stall always 0, wre_memory = 1, calc_data_out = 16'h1234, dmem_req never asserted.
- Load from address 16'h0040, memory ready on the first ACCESS cycle with rdata = 16'hBEEF → stall high for exactly 2 cycles, dmem_we = 0, data_from_memory_out = 16'hBEEF from DONE onward, wre_memory = 0 while stalled.
- Store of 16'hA5A5 to address 16'h0010 with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we = 1, dmem_wdata = 16'hA5A5, load register unchanged, 5 stall cycles.
- Two back-to-back loads (16'h0001 → 16'h1111, 16'h0002 → 16'h2222) → two separate request phases, data_from_memory_out shows 16'h1111 then 16'h2222, one DONE cycle between them.
- Reset asserted in the second ACCESS cycle → dmem_req = 0 and stall = 0 immediately, data_from_memory_out = 0, FSM in IDLE.
- MEM_TIMEOUT_EN defined, TIMEOUT = 15, dmem_ready held low → abort after 15 ACCESS cycles, mem_error = 1 and sticky, data_from_memory_out = 16'hFFFF for the read.
